// File: rtl/muldiv_unit_pkg.sv
// Shared op codes and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_MUL    = 5'h10;
    localparam logic [OP_W-1:0] OP_MULH   = 5'h11;
    localparam logic [OP_W-1:0] OP_MULHSU = 5'h12;
    localparam logic [OP_W-1:0] OP_MULHU  = 5'h13;
    localparam logic [OP_W-1:0] OP_DIV    = 5'h14;
    localparam logic [OP_W-1:0] OP_DIVU   = 5'h15;
    localparam logic [OP_W-1:0] OP_REM    = 5'h16;
    localparam logic [OP_W-1:0] OP_REMU   = 5'h17;

    typedef struct packed {
        logic is_mul;
        logic hi;
        logic rem;
        logic sgn1;
        logic sgn2;
    } op_dec_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // Low three bits select the operation within the M group.
    function automatic op_dec_t decode_op(input logic [2:0] f);
        op_dec_t d;
        d.is_mul = ~f[2];
        d.hi     = ~f[2] & (f[1:0] != 2'b00);
        d.rem    = f[2] & f[1];
        d.sgn1   = f[2] ? ~f[0] : (f[1:0] != 2'b11);
        d.sgn2   = f[2] ? ~f[0] : ~f[1];
        return d;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic            in_ready;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic            kill;
    logic            done;
    logic [XLEN-1:0] res;
    logic            div_zero;
    logic            illegal_op;

    modport master (
        output start, op, r1, r2, kill,
        input  in_ready, done, res, div_zero, illegal_op
    );

    modport slave (
        input  start, op, r1, r2, kill,
        output in_ready, done, res, div_zero, illegal_op
    );
endinterface

// File: rtl/muldiv_unit_step.sv
// One shift-add (multiply) or restoring trial-subtract (divide) iteration.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_mul,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN:0]   acc_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN:0]   acc_c,
    output logic [XLEN-1:0] lo_c
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum  = acc_i + (lo_i[0] ? {1'b0, b_i} : '0);
        shl  = {acc_i[XLEN-1:0], lo_i[XLEN-1]};
        diff = {1'b0, shl} - {2'b00, b_i};
        if (is_mul) begin
            acc_c = {1'b0, sum[XLEN:1]};
            lo_c  = {sum[0], lo_i[XLEN-1:1]};
        end else if (diff[XLEN+1]) begin
            acc_c = shl;
            lo_c  = {lo_i[XLEN-2:0], 1'b0};
        end else begin
            acc_c = diff[XLEN:0];
            lo_c  = {lo_i[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, operand/sign capture, step chain and sign fixup.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned N     = XLEN / UNROLL;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d, b_q, b_d, res_q, res_d;
    op_dec_t           dec_q, dec_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d, div_zero_q, div_zero_d;
    logic              illegal_op_q, illegal_op_d, in_ready_q, in_ready_d;

    logic              accept, legal, s1, s2, dz, ovf, fast;
    op_dec_t           dec;
    logic [XLEN-1:0]   mag1, mag2, fast_res, div_v, div_s, fix_res;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN:0]     acc_step;
    logic [XLEN-1:0]   lo_step;

    // Chain of UNROLL iterations, each stage fed by the previous one.
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        logic [XLEN:0]   acc_in, acc_out;
        logic [XLEN-1:0] lo_in, lo_out;
        if (g == 0) begin : g_first
            assign acc_in = acc_q;
            assign lo_in  = lo_q;
        end else begin : g_next
            assign acc_in = g_step[g-1].acc_out;
            assign lo_in  = g_step[g-1].lo_out;
        end
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_mul (dec_q.is_mul),
            .b_i    (b_q),
            .acc_i  (acc_in),
            .lo_i   (lo_in),
            .acc_c  (acc_out),
            .lo_c   (lo_out)
        );
    end
    assign acc_step = g_step[UNROLL-1].acc_out;
    assign lo_step  = g_step[UNROLL-1].lo_out;

    // Accept-time decode: magnitudes, special cases and their immediate results.
    always_comb begin
        accept   = bus.start & in_ready_q & ~bus.kill;
        legal    = is_muldiv(bus.op);
        dec      = decode_op(bus.op[2:0]);
        s1       = dec.sgn1 & bus.r1[XLEN-1];
        s2       = dec.sgn2 & bus.r2[XLEN-1];
        mag1     = s1 ? -bus.r1 : bus.r1;
        mag2     = s2 ? -bus.r2 : bus.r2;
        dz       = legal & ~dec.is_mul & (bus.r2 == '0);
        ovf      = legal & ~dec.is_mul & dec.sgn1 & (bus.r1 == XMIN) & (bus.r2 == '1);
        fast     = ~legal | dz | ovf;
        fast_res = '0;
        if (legal && dz) begin
            fast_res = dec.rem ? bus.r1 : '1;
        end else if (legal && ovf) begin
            fast_res = dec.rem ? '0 : XMIN;
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod    = {acc_q[XLEN-1:0], lo_q};
        prod_s  = neg_q ? -prod : prod;
        div_v   = dec_q.rem ? acc_q[XLEN-1:0] : lo_q;
        div_s   = neg_q ? -div_v : div_v;
        fix_res = div_s;
        if (dec_q.is_mul) begin
            fix_res = dec_q.hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? (fast ? DONE : CALC) : IDLE;
            CALC: begin
                if (bus.kill)          state_d = IDLE;
                else if (cnt_q == '0)  state_d = FIXUP;
            end
            FIXUP:   state_d = bus.kill ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        lo_d         = lo_q;
        b_d          = b_q;
        dec_d        = dec_q;
        neg_d        = neg_q;
        res_d        = res_q;
        illegal_op_d = illegal_op_q;
        div_zero_d   = 1'b0;
        done_d       = (state_d == DONE);
        in_ready_d   = (state_d == IDLE) || (state_d == DONE);
        case (state_q)
            CALC: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                cnt_d = cnt_q - CNT_W'(1);
            end
            FIXUP: if (!bus.kill) res_d = fix_res;
            default: ;
        endcase
        if (accept) begin
            illegal_op_d = ~legal;
            dec_d        = dec;
            if (fast) begin
                res_d      = fast_res;
                div_zero_d = dz;
            end else begin
                cnt_d = CNT_W'(N - 1);
                acc_d = '0;
                lo_d  = dec.is_mul ? mag2 : mag1;
                b_d   = dec.is_mul ? mag1 : mag2;
                neg_d = (dec.is_mul || !dec.rem) ? (s1 ^ s2) : s1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            lo_q         <= '0;
            b_q          <= '0;
            dec_q        <= '0;
            neg_q        <= 1'b0;
            res_q        <= '0;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
            illegal_op_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            lo_q         <= lo_d;
            b_q          <= b_d;
            dec_q        <= dec_d;
            neg_q        <= neg_d;
            res_q        <= res_d;
            done_q       <= done_d;
            div_zero_q   <= div_zero_d;
            illegal_op_q <= illegal_op_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.done       = done_q;
    assign bus.res        = res_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.illegal_op = illegal_op_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: UNROLL=1 and UNROLL=4 instances against a 64-bit arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    logic [31:0] last1, old_res;

    muldiv_unit_if #(.XLEN(32)) if1 ();
    muldiv_unit_if #(.XLEN(32)) if4 ();

    muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (.clk(clk), .reset(reset), .bus(if4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic and the RISC-V special-case rules.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input int n);
        exp_t e;
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        e.res = '0; e.dz = 1'b0; e.ill = 1'b0; e.acc = 0; e.lat = n + 2;
        case (op)
            OP_MUL:    begin p = sa * sb; e.res = p[31:0]; end
            OP_MULH:   begin p = sa * sb; e.res = p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); e.res = p[63:32]; end
            OP_MULHU:  begin up = ua * ub; e.res = up[63:32]; end
            OP_DIV, OP_REM: begin
                if (b == 32'h0) begin
                    e.res = (op == OP_DIV) ? 32'hFFFF_FFFF : a; e.dz = 1'b1; e.lat = 1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.res = (op == OP_DIV) ? 32'h8000_0000 : 32'h0; e.lat = 1;
                end else begin
                    e.res = (op == OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
                end
            end
            OP_DIVU, OP_REMU: begin
                if (b == 32'h0) begin
                    e.res = (op == OP_DIVU) ? 32'hFFFF_FFFF : a; e.dz = 1'b1; e.lat = 1;
                end else begin
                    e.res = (op == OP_DIVU) ? 32'(ua / ub) : 32'(ua % ub);
                end
            end
            default: begin e.ill = 1'b1; e.lat = 1; end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int sel, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t = 0;
        while (((sel == 1) ? if1.in_ready : if4.in_ready) !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL issue timeout on unit %0d: in_ready stuck low", sel);
            return;
        end
        e = model(op, a, b, (sel == 1) ? 32 : 8);
        e.acc = cyc + 1;
        if (sel == 1) begin
            if1.start = 1'b1; if1.op = op; if1.r1 = a; if1.r2 = b;
            q1.push_back(e); last1 = e.res;
        end else begin
            if4.start = 1'b1; if4.op = op; if4.r1 = a; if4.r2 = b;
            q4.push_back(e);
        end
        @(negedge clk);
        if (sel == 1) begin
            if1.start = 1'b0; if1.r1 = $urandom(); if1.r2 = $urandom(); if1.op = OP_MULHU;
            if (e.lat > 1) chk("u1 busy after accept", 32'(if1.in_ready), 32'(0));
        end else begin
            if4.start = 1'b0; if4.r1 = $urandom(); if4.r2 = $urandom(); if4.op = OP_REM;
        end
    endtask

    task automatic drain(input int sel);
        int t = 0;
        while (((sel == 1) ? q1.size() : q4.size()) != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++; errors++;
            $display("FAIL drain timeout on unit %0d: done never arrived", sel);
            if (sel == 1) q1.delete(); else q4.delete();
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [4:0] rnd_op();
        if ($urandom_range(0, 15) == 0) return 5'($urandom_range(0, 15));
        return 5'(16 + $urandom_range(0, 7));
    endfunction

    // Monitors: pop the oldest expectation whenever a unit reports done.
    always @(negedge clk) begin
        if (reset === 1'b1 && if1.done === 1'b1) begin
            if (q1.size() == 0) begin
                chk("u1 unexpected done", 32'(if1.done), 32'(0));
            end else begin
                e1 = q1.pop_front();
                chk("u1 res", if1.res, e1.res);
                chk("u1 div_zero", 32'(if1.div_zero), 32'(e1.dz));
                chk("u1 illegal_op", 32'(if1.illegal_op), 32'(e1.ill));
                chk("u1 latency", 32'(cyc - e1.acc + 1), 32'(e1.lat));
            end
        end else if (reset === 1'b1) begin
            chk("u1 div_zero without done", 32'(if1.div_zero), 32'(0));
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && if4.done === 1'b1) begin
            if (q4.size() == 0) begin
                chk("u4 unexpected done", 32'(if4.done), 32'(0));
            end else begin
                e4 = q4.pop_front();
                chk("u4 res", if4.res, e4.res);
                chk("u4 div_zero", 32'(if4.div_zero), 32'(e4.dz));
                chk("u4 illegal_op", 32'(if4.illegal_op), 32'(e4.ill));
                chk("u4 latency", 32'(cyc - e4.acc + 1), 32'(e4.lat));
            end
        end
    end

    logic [4:0]  d_op [12] = '{OP_MUL, OP_MULHU, OP_DIV, OP_REM, OP_DIVU, OP_DIV,
                               OP_REMU, OP_DIV, OP_REM, OP_MULH, OP_MULHSU, 5'h03};
    logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5,
                               32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd0,
                               32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd2};

    initial begin
        reset = 1'b0;
        if1.start = 1'b0; if1.kill = 1'b0; if1.op = '0; if1.r1 = '0; if1.r2 = '0;
        if4.start = 1'b0; if4.kill = 1'b0; if4.op = '0; if4.r1 = '0; if4.r2 = '0;
        last1 = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 32'(if1.in_ready), 32'(1));
        chk("reset done", 32'(if1.done), 32'(0));
        chk("reset res", if1.res, 32'h0);
        chk("reset div_zero", 32'(if1.div_zero), 32'(0));
        chk("reset illegal_op", 32'(if1.illegal_op), 32'(0));
        chk("reset u4 in_ready", 32'(if4.in_ready), 32'(1));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) issue(1, d_op[i], d_a[i], d_b[i]);
        drain(1);

        // kill together with start while idle/done: nothing is accepted
        if1.kill = 1'b1; if1.start = 1'b1; if1.op = OP_MUL; if1.r1 = 32'd3; if1.r2 = 32'd3;
        @(negedge clk);
        if1.kill = 1'b0; if1.start = 1'b0;
        chk("kill+start idle in_ready", 32'(if1.in_ready), 32'(1));

        // kill mid-CALC with a simultaneous start
        old_res = last1;
        issue(1, OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        if1.kill = 1'b1; if1.start = 1'b1; if1.op = OP_MUL; if1.r1 = 32'd3; if1.r2 = 32'd3;
        @(negedge clk);
        if1.kill = 1'b0; if1.start = 1'b0;
        void'(q1.pop_back());
        last1 = old_res;
        chk("kill in_ready", 32'(if1.in_ready), 32'(1));
        chk("kill res held", if1.res, old_res);
        issue(1, OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        drain(1);

        // asynchronous reset mid-CALC
        issue(1, OP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        q1.delete();
        #1;
        chk("mid reset in_ready", 32'(if1.in_ready), 32'(1));
        chk("mid reset done", 32'(if1.done), 32'(0));
        chk("mid reset res", if1.res, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1, OP_DIV, 32'd100, 32'd7);
        drain(1);

        for (int i = 0; i < 16; i++) issue(1, rnd_op(), rnd_opnd(), rnd_opnd());
        drain(1);

        for (int i = 0; i < 300; i++) issue(4, rnd_op(), rnd_opnd(), rnd_opnd());
        drain(4);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
